// File: rtl/sha256_mux_pkg.sv
// sha256_mux_pkg
// Shared types and helpers for the SHA-256 hash multiplexer slice.
//   calc_id_w   : width of a channel ID for a given channel count (minimum 1)
//   CH_ID_W     : channel ID width for the default 4-channel build
//   mux_state_t : arbitration FSM states (IDLE waits for a grant, BUSY streams a message)
//   cfg_t       : one configuration beat (message size and scheme)
package sha256_mux_pkg;

    // A single-channel build still needs a 1-bit ID so the FIFO has storage.
    function automatic int calc_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CH_ID_W = calc_id_w(4);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mux_state_t;

    typedef struct packed {
        logic [63:0] size;
        logic [1:0]  scheme;
    } cfg_t;

endpackage

// File: rtl/sha256_mux_rr_arb.sv
// sha256_mux_rr_arb
// Combinational round-robin arbiter: picks the first requesting channel
// searching upward from rr_ptr, wrapping at NUM_CH.
// Ports:
//   req       in  NUM_CH  request vector
//   rr_ptr    in  ID_W    highest-priority index for this search
//   gnt       out NUM_CH  one-hot grant (all zero when nothing requests)
//   gnt_id    out ID_W    encoded index of the grant
//   gnt_valid out 1       some channel was granted
import sha256_mux_pkg::*;

module sha256_mux_rr_arb #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = calc_id_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [ID_W-1:0]   rr_ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [ID_W-1:0]   gnt_id,
    output logic              gnt_valid
);

    // Walk the offsets from rr_ptr; the first hit wins and later hits are ignored.
    always_comb begin
        int idx;
        idx       = 0;
        gnt       = '0;
        gnt_id    = '0;
        gnt_valid = 1'b0;
        for (int off = 0; off < NUM_CH; off++) begin
            idx = (int'(rr_ptr) + off) % NUM_CH;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt[idx]  = 1'b1;
                gnt_id    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sha256_hash_mux.sv
// sha256_hash_mux
// Shares one SHA-256 engine between NUM_CH requesters. Whole messages (data
// and cfg streams) are granted round-robin; the granted channel ID is queued
// in an in-order FIFO so each returned hash is routed to its requester.
// Ports:
//   clk, sync_rst (synchronous, active-high), en (low freezes all state)
//   ch_data_in*/ch_cfg_*      per-channel request streams (ready driven here)
//   eng_data_out*/eng_cfg_*   muxed streams to the engine
//   eng_hash_in*              hash stream from the engine
//   ch_hash_out*              per-channel hash streams (data/last broadcast)
// Optional: define SHA256_HASH_MUX_STATS_EN to add ch_msg_count, a per-channel
// 32-bit count of hashes delivered.
import sha256_mux_pkg::*;

module sha256_hash_mux #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 512,
    parameter int HASH_W   = 256,
    parameter int ID_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       sync_rst,
    input  logic                       en,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data_in,
    input  logic [NUM_CH-1:0]          ch_data_in_last,
    input  logic [NUM_CH-1:0]          ch_data_in_valid,
    output logic [NUM_CH-1:0]          ch_data_in_ready,
    input  logic [NUM_CH*64-1:0]       ch_cfg_size,
    input  logic [NUM_CH*2-1:0]        ch_cfg_scheme,
    input  logic [NUM_CH-1:0]          ch_cfg_last,
    input  logic [NUM_CH-1:0]          ch_cfg_valid,
    output logic [NUM_CH-1:0]          ch_cfg_ready,
    output logic [DATA_W-1:0]          eng_data_out,
    output logic                       eng_data_out_last,
    output logic                       eng_data_out_valid,
    input  logic                       eng_data_out_ready,
    output logic [63:0]                eng_cfg_size,
    output logic [1:0]                 eng_cfg_scheme,
    output logic                       eng_cfg_last,
    output logic                       eng_cfg_valid,
    input  logic                       eng_cfg_ready,
    input  logic [HASH_W-1:0]          eng_hash_in,
    input  logic                       eng_hash_in_last,
    input  logic                       eng_hash_in_valid,
    output logic                       eng_hash_in_ready,
    output logic [NUM_CH*HASH_W-1:0]   ch_hash_out,
    output logic [NUM_CH-1:0]          ch_hash_out_last,
    output logic [NUM_CH-1:0]          ch_hash_out_valid,
    input  logic [NUM_CH-1:0]          ch_hash_out_ready
`ifdef SHA256_HASH_MUX_STATS_EN
    ,
    output logic [NUM_CH*32-1:0]       ch_msg_count
`endif
);

    localparam int ID_W  = calc_id_w(NUM_CH);
    localparam int PTR_W = (ID_DEPTH > 1) ? $clog2(ID_DEPTH) : 1;

    mux_state_t        state;
    logic [ID_W-1:0]   gnt;
    logic [ID_W-1:0]   rr_ptr;
    logic              data_done;
    logic              cfg_done;

    logic [ID_W-1:0]   id_mem [ID_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    id_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ID_W-1:0]   head;

    logic [NUM_CH-1:0] arb_gnt;
    logic [ID_W-1:0]   arb_id;
    logic              arb_valid;

    logic              busy;
    logic              data_last_hs;
    logic              cfg_last_hs;
    logic              push;
    logic              pop;
    cfg_t              sel_cfg;

    sha256_mux_rr_arb #(
        .NUM_CH (NUM_CH),
        .ID_W   (ID_W)
    ) u_arb (
        .req       (ch_data_in_valid | ch_cfg_valid),
        .rr_ptr    (rr_ptr),
        .gnt       (arb_gnt),
        .gnt_id    (arb_id),
        .gnt_valid (arb_valid)
    );

    assign fifo_full  = (id_count == (PTR_W+1)'(ID_DEPTH));
    assign fifo_empty = (id_count == '0);
    assign head       = id_mem[rd_ptr];
    assign busy       = (state == BUSY);

    // Forward path: the granted channel's streams go to the engine. Valid is
    // masked once that stream's last beat has gone, so a channel that already
    // started its next message cannot leak beats into this one.
    always_comb begin
        sel_cfg.size       = ch_cfg_size[int'(gnt)*64 +: 64];
        sel_cfg.scheme     = ch_cfg_scheme[int'(gnt)*2 +: 2];
        eng_data_out       = ch_data_in[int'(gnt)*DATA_W +: DATA_W];
        eng_data_out_last  = ch_data_in_last[gnt];
        eng_data_out_valid = en & busy & ~data_done & ch_data_in_valid[gnt];
        eng_cfg_size       = sel_cfg.size;
        eng_cfg_scheme     = sel_cfg.scheme;
        eng_cfg_last       = ch_cfg_last[gnt];
        eng_cfg_valid      = en & busy & ~cfg_done & ch_cfg_valid[gnt];
        ch_data_in_ready        = '0;
        ch_data_in_ready[gnt]   = en & busy & ~data_done & eng_data_out_ready;
        ch_cfg_ready            = '0;
        ch_cfg_ready[gnt]       = en & busy & ~cfg_done & eng_cfg_ready;
    end

    // Return path: only the FIFO head may see valid, so a hash without a
    // recorded owner is never accepted.
    always_comb begin
        ch_hash_out       = {NUM_CH{eng_hash_in}};
        ch_hash_out_last  = {NUM_CH{eng_hash_in_last}};
        ch_hash_out_valid = '0;
        eng_hash_in_ready = 1'b0;
        if (en && !fifo_empty) begin
            ch_hash_out_valid[head] = eng_hash_in_valid;
            eng_hash_in_ready       = ch_hash_out_ready[head];
        end
    end

    assign data_last_hs = eng_data_out_valid & eng_data_out_ready & eng_data_out_last;
    assign cfg_last_hs  = eng_cfg_valid & eng_cfg_ready & eng_cfg_last;
    assign push         = en & ~busy & arb_valid & ~fifo_full;
    assign pop          = eng_hash_in_valid & eng_hash_in_ready & eng_hash_in_last;

    // Arbitration FSM and ID FIFO pointers. A message ends only when both the
    // data and cfg streams have seen their last beat, in either order.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state     <= IDLE;
            gnt       <= '0;
            rr_ptr    <= '0;
            data_done <= 1'b0;
            cfg_done  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            id_count  <= '0;
        end else if (en) begin
            if (busy) begin
                if (data_last_hs) data_done <= 1'b1;
                if (cfg_last_hs)  cfg_done  <= 1'b1;
                if ((data_done | data_last_hs) && (cfg_done | cfg_last_hs))
                    state <= IDLE;
            end else if (push) begin
                state     <= BUSY;
                gnt       <= arb_id;
                rr_ptr    <= (int'(arb_id) == NUM_CH-1) ? '0 : arb_id + 1'b1;
                data_done <= 1'b0;
                cfg_done  <= 1'b0;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      id_count <= id_count + 1'b1;
            else if (!push && pop) id_count <= id_count - 1'b1;
        end
    end

    // ID storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) id_mem[wr_ptr] <= arb_id;
    end

`ifdef SHA256_HASH_MUX_STATS_EN
    logic [31:0] msg_cnt [NUM_CH];

    // Counts completed hashes per owner; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            for (int i = 0; i < NUM_CH; i++) msg_cnt[i] <= '0;
        end else if (pop) begin
            msg_cnt[head] <= msg_cnt[head] + 32'd1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        assign ch_msg_count[g*32 +: 32] = msg_cnt[g];
    end
`endif

endmodule

// File: tb/tb_sha256_hash_mux.sv
// tb_sha256_hash_mux
// Directed bench for sha256_hash_mux (4 channels, default widths). The bench
// plays the engine role directly: it drives the engine readies and returns
// hashes by hand. Inputs change 1 time unit after the rising edge and outputs
// are checked 1 time unit later.
// Optional: define SHA256_HASH_MUX_STATS_EN to also check ch_msg_count.
module tb_sha256_hash_mux;

    localparam int NUM_CH   = 4;
    localparam int DATA_W   = 512;
    localparam int HASH_W   = 256;
    localparam int ID_DEPTH = 4;

    logic                       clk;
    logic                       sync_rst;
    logic                       en;
    logic [NUM_CH*DATA_W-1:0]   ch_data_in;
    logic [NUM_CH-1:0]          ch_data_in_last;
    logic [NUM_CH-1:0]          ch_data_in_valid;
    logic [NUM_CH-1:0]          ch_data_in_ready;
    logic [NUM_CH*64-1:0]       ch_cfg_size;
    logic [NUM_CH*2-1:0]        ch_cfg_scheme;
    logic [NUM_CH-1:0]          ch_cfg_last;
    logic [NUM_CH-1:0]          ch_cfg_valid;
    logic [NUM_CH-1:0]          ch_cfg_ready;
    logic [DATA_W-1:0]          eng_data_out;
    logic                       eng_data_out_last;
    logic                       eng_data_out_valid;
    logic                       eng_data_out_ready;
    logic [63:0]                eng_cfg_size;
    logic [1:0]                 eng_cfg_scheme;
    logic                       eng_cfg_last;
    logic                       eng_cfg_valid;
    logic                       eng_cfg_ready;
    logic [HASH_W-1:0]          eng_hash_in;
    logic                       eng_hash_in_last;
    logic                       eng_hash_in_valid;
    logic                       eng_hash_in_ready;
    logic [NUM_CH*HASH_W-1:0]   ch_hash_out;
    logic [NUM_CH-1:0]          ch_hash_out_last;
    logic [NUM_CH-1:0]          ch_hash_out_valid;
    logic [NUM_CH-1:0]          ch_hash_out_ready;
`ifdef SHA256_HASH_MUX_STATS_EN
    logic [NUM_CH*32-1:0]       ch_msg_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    sha256_hash_mux #(
        .NUM_CH   (NUM_CH),
        .DATA_W   (DATA_W),
        .HASH_W   (HASH_W),
        .ID_DEPTH (ID_DEPTH)
    ) dut (
        .clk                (clk),
        .sync_rst           (sync_rst),
        .en                 (en),
        .ch_data_in         (ch_data_in),
        .ch_data_in_last    (ch_data_in_last),
        .ch_data_in_valid   (ch_data_in_valid),
        .ch_data_in_ready   (ch_data_in_ready),
        .ch_cfg_size        (ch_cfg_size),
        .ch_cfg_scheme      (ch_cfg_scheme),
        .ch_cfg_last        (ch_cfg_last),
        .ch_cfg_valid       (ch_cfg_valid),
        .ch_cfg_ready       (ch_cfg_ready),
        .eng_data_out       (eng_data_out),
        .eng_data_out_last  (eng_data_out_last),
        .eng_data_out_valid (eng_data_out_valid),
        .eng_data_out_ready (eng_data_out_ready),
        .eng_cfg_size       (eng_cfg_size),
        .eng_cfg_scheme     (eng_cfg_scheme),
        .eng_cfg_last       (eng_cfg_last),
        .eng_cfg_valid      (eng_cfg_valid),
        .eng_cfg_ready      (eng_cfg_ready),
        .eng_hash_in        (eng_hash_in),
        .eng_hash_in_last   (eng_hash_in_last),
        .eng_hash_in_valid  (eng_hash_in_valid),
        .eng_hash_in_ready  (eng_hash_in_ready),
        .ch_hash_out        (ch_hash_out),
        .ch_hash_out_last   (ch_hash_out_last),
        .ch_hash_out_valid  (ch_hash_out_valid),
        .ch_hash_out_ready  (ch_hash_out_ready)
`ifdef SHA256_HASH_MUX_STATS_EN
        ,
        .ch_msg_count       (ch_msg_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-channel data and hash patterns used throughout the directed steps.
    function automatic logic [DATA_W-1:0] dataPat(input int ch);
        return {16{32'hD000_0000 | 32'(ch)}};
    endfunction

    function automatic logic [HASH_W-1:0] hashPat(input int ch);
        return {8{32'hA500_0000 | 32'(ch)}};
    endfunction

    task automatic checkOutput(input string tag, input logic [511:0] observed,
                               input logic [511:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] dv, input logic [3:0] dl,
                                 input logic [3:0] cv, input logic [3:0] cl);
        ch_data_in_valid = dv;
        ch_data_in_last  = dl;
        ch_cfg_valid     = cv;
        ch_cfg_last      = cl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sendHash(input int ch);
        eng_hash_in       = hashPat(ch);
        eng_hash_in_last  = 1'b1;
        eng_hash_in_valid = 1'b1;
    endtask

    initial begin
        int order [4];

        sync_rst           = 1'b1;
        en                 = 1'b1;
        ch_data_in         = '0;
        ch_cfg_size        = '0;
        ch_cfg_scheme      = '0;
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        eng_data_out_ready = 1'b0;
        eng_cfg_ready      = 1'b0;
        eng_hash_in        = '0;
        eng_hash_in_last   = 1'b0;
        eng_hash_in_valid  = 1'b0;
        ch_hash_out_ready  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_data_in[i*DATA_W +: DATA_W] = dataPat(i);
            ch_cfg_size[i*64 +: 64]        = 64'h100 * 64'(i + 1);
            ch_cfg_scheme[i*2 +: 2]        = 2'(i);
        end
        tick;
        tick;

        // Reset state: nothing ready or valid, and an orphan hash is refused.
        sync_rst          = 1'b0;
        ch_hash_out_ready = 4'b1111;
        sendHash(0);
        #1;
        checkOutput("rst_data_rdy",  ch_data_in_ready,   0);
        checkOutput("rst_cfg_rdy",   ch_cfg_ready,       0);
        checkOutput("rst_eng_dv",    eng_data_out_valid, 0);
        checkOutput("rst_eng_cv",    eng_cfg_valid,      0);
        checkOutput("rst_hash_rdy",  eng_hash_in_ready,  0);
        checkOutput("rst_hash_vld",  ch_hash_out_valid,  0);
        eng_hash_in_valid  = 1'b0;
        eng_data_out_ready = 1'b1;
        eng_cfg_ready      = 1'b1;
        tick;

        // Channel 2: 3 data beats plus one cfg beat, engine always ready.
        applyStimulus(4'b0100, 4'b0000, 4'b0100, 4'b0100);
        #1;
        checkOutput("t1_idle_rdy", ch_data_in_ready, 0);
        tick;
        checkOutput("t1_data_rdy", ch_data_in_ready, 4'b0100);
        checkOutput("t1_cfg_rdy",  ch_cfg_ready,     4'b0100);
        checkOutput("t1_data",     eng_data_out,     dataPat(2));
        checkOutput("t1_size",     eng_cfg_size,     64'h300);
        checkOutput("t1_scheme",   eng_cfg_scheme,   2'd2);
        checkOutput("t1_cfg_vld",  eng_cfg_valid,    1);
        tick;
        ch_data_in[2*DATA_W +: DATA_W] = {16{32'hB2B2_0002}};
        applyStimulus(4'b0100, 4'b0000, 4'b0000, 4'b0000);
        #1;
        checkOutput("t1_cfg_done_rdy", ch_cfg_ready,     0);
        checkOutput("t1_beat2_rdy",    ch_data_in_ready, 4'b0100);
        checkOutput("t1_beat2",        eng_data_out,     {16{32'hB2B2_0002}});
        tick;
        applyStimulus(4'b0100, 4'b0100, 4'b0000, 4'b0000);
        #1;
        checkOutput("t1_beat3_last", eng_data_out_last, 1);
        checkOutput("t1_beat3_rdy",  ch_data_in_ready,  4'b0100);
        tick;
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        ch_data_in[2*DATA_W +: DATA_W] = dataPat(2);
        sendHash(2);
        #1;
        checkOutput("t1_back_idle",  ch_data_in_ready,  0);
        checkOutput("t1_hash_vld",   ch_hash_out_valid, 4'b0100);
        checkOutput("t1_hash_rdy",   eng_hash_in_ready, 1);
        checkOutput("t1_hash2",      ch_hash_out[2*HASH_W +: HASH_W], hashPat(2));
        checkOutput("t1_hash_bcast", ch_hash_out[0 +: HASH_W],        hashPat(2));
        tick;
        checkOutput("t1_fifo_empty", eng_hash_in_ready, 0);
        checkOutput("t1_no_vld",     ch_hash_out_valid, 0);
        eng_hash_in_valid = 1'b0;

        // Reset so the round-robin pointer starts at 0.
        sync_rst = 1'b1;
        tick;
        sync_rst = 1'b0;

        // All channels request single-beat messages; the engine returns nothing
        // until the ID FIFO has filled.
        applyStimulus(4'b1111, 4'b1111, 4'b1111, 4'b1111);
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("t2_idle_rdy", ch_data_in_ready, 0);
            tick;
            checkOutput("t2_grant",    ch_data_in_ready, 4'b0001 << k);
            checkOutput("t2_data",     eng_data_out,     dataPat(k));
            tick;
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("t2_full_stall", ch_data_in_ready, 0);
            tick;
        end
        sendHash(0);
        #1;
        checkOutput("t2_pop_vld", ch_hash_out_valid, 4'b0001);
        tick;
        eng_hash_in_valid = 1'b0;
        #1;
        checkOutput("t2_post_pop_idle", ch_data_in_ready, 0);
        tick;
        checkOutput("t2_grant5", ch_data_in_ready, 4'b0001);
        tick;
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        order = '{1, 2, 3, 0};
        for (int k = 0; k < 4; k++) begin
            sendHash(order[k]);
            #1;
            checkOutput("t2_route_vld",  ch_hash_out_valid, 4'b0001 << order[k]);
            checkOutput("t2_route_hash", ch_hash_out[order[k]*HASH_W +: HASH_W], hashPat(order[k]));
            tick;
        end
        eng_hash_in_valid = 1'b0;
        #1;
        checkOutput("t2_drained", eng_hash_in_ready, 0);
        tick;

        // Channel 1 finishes data but holds cfg back; channel 0 must wait.
        applyStimulus(4'b0011, 4'b0011, 4'b0001, 4'b0001);
        #1;
        checkOutput("t3_idle_rdy", ch_data_in_ready, 0);
        tick;
        checkOutput("t3_grant1",   ch_data_in_ready, 4'b0010);
        checkOutput("t3_cfg_rdy",  ch_cfg_ready,     4'b0010);
        checkOutput("t3_cfg_vld0", eng_cfg_valid,    0);
        tick;
        applyStimulus(4'b0001, 4'b0001, 4'b0001, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput("t3_hold_drdy", ch_data_in_ready,   0);
            checkOutput("t3_hold_crdy", ch_cfg_ready,       4'b0010);
            checkOutput("t3_hold_dvld", eng_data_out_valid, 0);
            tick;
        end
        en = 1'b0;
        #1;
        checkOutput("t3_en_low_rdy", ch_cfg_ready, 0);
        tick;
        en = 1'b1;
        applyStimulus(4'b0001, 4'b0001, 4'b0011, 4'b0011);
        #1;
        checkOutput("t3_cfg_last_vld", eng_cfg_valid, 1);
        checkOutput("t3_cfg_last_rdy", ch_cfg_ready,  4'b0010);
        tick;
        applyStimulus(4'b0001, 4'b0001, 4'b0001, 4'b0001);
        #1;
        checkOutput("t3_idle_after", ch_data_in_ready, 0);
        tick;
        checkOutput("t3_grant0", ch_data_in_ready, 4'b0001);
        tick;
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Head channel 1 not ready for 10 cycles: hash held, no pop.
        ch_hash_out_ready = 4'b0000;
        sendHash(1);
        for (int k = 0; k < 10; k++) begin
            #1;
            checkOutput("t5_stall_rdy",  eng_hash_in_ready, 0);
            checkOutput("t5_stall_vld",  ch_hash_out_valid, 4'b0010);
            checkOutput("t5_stall_hash", ch_hash_out[1*HASH_W +: HASH_W], hashPat(1));
            tick;
        end
        ch_hash_out_ready = 4'b1111;
        #1;
        checkOutput("t5_release_rdy", eng_hash_in_ready, 1);
        tick;
        sendHash(0);
        #1;
        checkOutput("t5_next_head", ch_hash_out_valid, 4'b0001);
        tick;
        eng_hash_in_valid = 1'b0;

        // Reset in the middle of a channel 2 data stream.
        applyStimulus(4'b0100, 4'b0000, 4'b0100, 4'b0000);
        #1;
        tick;
        checkOutput("t6_busy", ch_data_in_ready, 4'b0100);
        sync_rst = 1'b1;
        sendHash(2);
        tick;
        sync_rst = 1'b0;
        applyStimulus(4'b1010, 4'b1010, 4'b1010, 4'b1010);
        #1;
        checkOutput("t6_data_rdy", ch_data_in_ready,   0);
        checkOutput("t6_cfg_rdy",  ch_cfg_ready,       0);
        checkOutput("t6_eng_dv",   eng_data_out_valid, 0);
        checkOutput("t6_hash_rdy", eng_hash_in_ready,  0);
        checkOutput("t6_hash_vld", ch_hash_out_valid,  0);
`ifdef SHA256_HASH_MUX_STATS_EN
        checkOutput("t6_count_clr", ch_msg_count, 0);
`endif
        eng_hash_in_valid = 1'b0;
        tick;
        checkOutput("t6_rr_reset", ch_data_in_ready, 4'b0010);
        tick;
        applyStimulus(4'b1000, 4'b1000, 4'b1000, 4'b1000);
        tick;
        checkOutput("t6_grant3a", ch_data_in_ready, 4'b1000);
        tick;
        tick;
        checkOutput("t6_grant3b", ch_data_in_ready, 4'b1000);
        tick;
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        order = '{1, 3, 3, 0};
        for (int k = 0; k < 3; k++) begin
            sendHash(order[k]);
            #1;
            checkOutput("t6_route_vld", ch_hash_out_valid, 4'b0001 << order[k]);
            tick;
        end
        eng_hash_in_valid = 1'b0;
        #1;
        checkOutput("t6_drained", eng_hash_in_ready, 0);
`ifdef SHA256_HASH_MUX_STATS_EN
        checkOutput("t6_count3", ch_msg_count[3*32 +: 32], 2);
        checkOutput("t6_count1", ch_msg_count[1*32 +: 32], 1);
        checkOutput("t6_count0", ch_msg_count[0 +: 32],    0);
`endif
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sha256_hash_mux.md
Name: sha256_hash_mux

Overview:
- Parametrised N-channel front-end that shares one SHA-256 engine between NUM_CH independent requesters.
- Arbitrates whole messages (data and cfg streams) round-robin into the engine's data and cfg inputs.
- Records the granted channel in an in-order ID FIFO and routes each returned hash back to its requester.
- Sits between system-side channel adapters and the single SHA-256 engine instance.

Parameters:
- NUM_CH, 4, number of requester channels (2..16).
- DATA_W, 512, message data beat width.
- HASH_W, 256, hash width.
- ID_DEPTH, 4, outstanding-message ID FIFO depth (power of 2).

Ports:
- clk  in  1  clock.
- sync_rst  in  1  reset, synchronous, active-high.
- en  in  1  global enable; low freezes all state.
- ch_data_in  in  NUM_CH*DATA_W  per-channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- ch_data_in_last / ch_data_in_valid  in  NUM_CH  per-channel data framing and valid.
- ch_data_in_ready  out  NUM_CH  per-channel data ready.
- ch_cfg_size  in  NUM_CH*64  per-channel message size.
- ch_cfg_scheme  in  NUM_CH*2  per-channel scheme.
- ch_cfg_last / ch_cfg_valid  in  NUM_CH  per-channel cfg framing and valid.
- ch_cfg_ready  out  NUM_CH  per-channel cfg ready.
- eng_data_out / eng_data_out_last / eng_data_out_valid  out  DATA_W/1/1  data to engine.
- eng_data_out_ready  in  1  engine data ready.
- eng_cfg_size / eng_cfg_scheme / eng_cfg_last / eng_cfg_valid  out  64/2/1/1  cfg to engine.
- eng_cfg_ready  in  1  engine cfg ready.
- eng_hash_in / eng_hash_in_last / eng_hash_in_valid  in  HASH_W/1/1  hash from engine.
- eng_hash_in_ready  out  1  hash ready to engine.
- ch_hash_out  out  NUM_CH*HASH_W  per-channel hash.
- ch_hash_out_last / ch_hash_out_valid  out  NUM_CH  per-channel hash framing and valid.
- ch_hash_out_ready  in  NUM_CH  per-channel hash ready.

Behaviour:
- Reset (sync_rst sampled high on clk): state IDLE, rr_ptr=0, ID FIFO empty, grant cleared.
  - All ready/valid outputs 0 in the cycle after reset.
  - Reset mid-message drops the message and any in-flight IDs; the engine must be reset alongside.
- en=0: no register updates; all ready/valid outputs forced 0. Data outputs hold their values.
- FSM states:
  - IDLE: a channel is requesting if ch_data_in_valid[i] or ch_cfg_valid[i], and the ID FIFO is not full.
    - Grant goes to the first requesting index searching from rr_ptr upward, with wrap.
    - Registered: go to BUSY, gnt=i, push i into the ID FIFO, rr_ptr=(i+1)%NUM_CH, data_done=cfg_done=0.
    - One cycle arbitration latency; no readies asserted while in IDLE.
  - BUSY: data and cfg of channel gnt are muxed to the engine combinationally.
    - ch_data_in_ready[gnt]=eng_data_out_ready & ~data_done; ch_cfg_ready[gnt]=eng_cfg_ready & ~cfg_done; all other readies 0.
    - eng_*_valid is masked by the matching *_done flag.
    - data_done sets on a data handshake with last; cfg_done sets on a cfg handshake with last.
    - When both are set, or both complete in the same cycle, go to IDLE.
    - No re-arbitration in the same cycle; minimum 2 cycles per message.
- ID FIFO full in IDLE: no grant; a new grant is possible the cycle after a pop frees a slot.
- Return path: with the ID FIFO non-empty and head=h:
  - ch_hash_out_valid[h]=eng_hash_in_valid; eng_hash_in_ready=ch_hash_out_ready[h].
  - Hash and last are broadcast to all ch_hash_out slices; only valid[h] asserts.
- ID pop occurs on a hash handshake with eng_hash_in_last=1.
- ID FIFO empty: eng_hash_in_ready=0 and all ch_hash_out_valid=0. A hash with no recorded ID is never accepted.
- Simultaneous push and pop in one cycle: both take effect; count unchanged.
- Ordering: hashes are returned in grant order. The engine must preserve message order.

Optional Feature:
- Macro: SHA256_HASH_MUX_STATS_EN.
- When defined:
  - Adds output ch_msg_count, NUM_CH*32 bits.
  - Per-channel counter increments on each hash handshake with last for that channel.
  - Wraps at 2^32. Cleared by sync_rst; frozen when en=0.
- When undefined: no port and no counter logic.

Decomposition:
- Package sha256_mux_pkg:
  - ID width constant: CH_ID_W = $clog2(NUM_CH), minimum 1.
  - FSM enum mux_state_t {IDLE, BUSY}.
  - Cfg struct {size[63:0], scheme[1:0]}.
- One natural sub-module, sha256_mux_rr_arb: NUM_CH-wide round-robin arbiter.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant and encoded ID.
- The ID FIFO is inline (shallow register array).

Test Plan:
- Single channel 2 messaging: 3 data beats + 1 cfg, engine always ready -> grant 1 cycle after valid; ch_hash_out_valid[2] only; ID FIFO returns to empty.
- All 4 channels request continuously, rr_ptr=0 -> grants 0,1,2,3,0 in order; each hash delivered to the matching channel.
- Channel 1 holds cfg back for 5 cycles after data last -> stays BUSY; no other channel is granted until the cfg last handshake.
- ID_DEPTH=4, engine returns no hashes, 6 single-beat requests -> exactly 4 grants, then stall; the 5th grant occurs the cycle after the first hash pop.
- ch_hash_out_ready[head]=0 for 10 cycles -> eng_hash_in_ready=0; hash held stable; no pop.
- sync_rst asserted while BUSY mid-data -> next cycle all readies/valids 0, FIFO empty, rr_ptr=0.
  - With SHA256_HASH_MUX_STATS_EN: counters read 0 after reset, and channel 3 reads 2 after two returned hashes.
